lcd_nibble_driver: RTL and testbench
====================================

// Module: lcd_nibble_driver
// PURPOSE
//  Downstream of mcu_single_cycle: the MCU writes bytes with a valid/ready handshake.
//  Drives an HD44780-style character LCD in 4-bit mode on lcd_dataout/lcd_control.
//  Runs the power-up init sequence autonomously, then splits each byte into high/low
//  nibbles with timed E strobes and post-command waits. Frees the MCU from LCD timing.
// PARAMETERS
//  POWERUP_CYC   750000  idle cycles after reset before the first init nibble
//  INIT_WAIT_CYC 250000  wait after each init nibble
//  SETUP_CYC     4       cycles data/RS are stable with E=0, before and after each E pulse
//  E_PULSE_CYC   12      cycles E is held high per nibble
//  CMD_WAIT_CYC  2500    wait after a normal byte
//  LONG_WAIT_CYC 100000  wait after clear/home (RS=0, data 0x01..0x03)
//  All values 1..2^20-1; a single 20-bit down-counter times every phase.
// PORTS
//  clk_in       in   1  system clock
//  nClear       in   1  asynchronous active-low reset
//  wr_valid     in   1  MCU presents a byte
//  wr_rs        in   1  0=command, 1=character data
//  wr_data      in   8  byte to send
//  wr_ready     out  1  driver can accept a byte this cycle
//  busy         out  1  ~wr_ready (init, transfer, or wait in progress)
//  lcd_dataout  out  4  LCD DB7..DB4
//  lcd_control  out  3  [2]=E, [1]=RW, [0]=RS
// BEHAVIOUR
//  Reset (async, nClear=0): state=POWERUP, counter=POWERUP_CYC, lcd_dataout=0,
//   lcd_control=3'b000, wr_ready=0, busy=1. E falls immediately, even mid-pulse.
//  RW is always 0. Reads and busy-flag polling are not supported.
//  Nibble strobe (NIB): SETUP_CYC cycles E=0 -> E_PULSE_CYC cycles E=1 -> SETUP_CYC
//   cycles E=0. lcd_dataout and RS stay constant for the whole NIB.
//  Init: POWERUP -> four NIBs with RS=0, data 0x3,0x3,0x3,0x2 -> INIT_WAIT_CYC after
//   each NIB -> IDLE. Only nibbles are sent; the function-set command is the MCU's job.
//  IDLE: wr_ready=1. A byte is accepted on a clk_in edge with wr_valid&wr_ready.
//   wr_ready drops in the next cycle. wr_rs/wr_data are latched at acceptance and may
//   then change.
//  Transfer: NIB(data[7:4]) -> NIB(data[3:0]) -> WAIT -> IDLE.
//   WAIT lasts LONG_WAIT_CYC if rs=0 and data is 0x01, 0x02 or 0x03; otherwise CMD_WAIT_CYC.
//  Latency: wr_ready reasserts exactly 2*(2*SETUP_CYC+E_PULSE_CYC)+WAIT cycles after
//   the accept edge.
//  wr_valid outside IDLE is ignored; there is no queue. The MCU must hold valid until ready.
//  Outputs are registered (no combinational path from inputs to the LCD pins).
//   In IDLE, lcd_dataout holds the last nibble sent.
//  States: POWERUP, INIT_SU, INIT_E, INIT_HD, INIT_WAIT, IDLE, HI_SU, HI_E, HI_HD,
//   LO_SU, LO_E, LO_HD, WAIT. Each state exits when the counter hits 1, which reloads
//   the counter for the next state. A 2-bit init index selects the init nibble and
//   ends init after index 3.
// TESTING (bench params: POWERUP=10 INIT_WAIT=8 SETUP=2 E_PULSE=3 CMD_WAIT=5 LONG_WAIT=20)
//  1 Reset release -> 10 idle cycles, then 4 E pulses of 3 cycles with data 3,3,3,2 and
//    RS=0, 15 cycles apart. wr_ready first rises 10+4*15=70 cycles after release.
//  2 Write rs=1, data 0x48 -> E pulses carry 0x4 then 0x8, RS=1, RW=0.
//    wr_ready returns exactly 19 cycles after the accept edge.
//  3 Write rs=0, data 0x01 -> 0x0/0x1, RS=0, wr_ready back after 34 cycles.
//    rs=1, data 0x01 -> back after 19 cycles.
//  4 Change wr_valid/wr_data mid-transfer -> no effect on the pins, nothing accepted
//    until wr_ready. Back-to-back writes with valid held high -> one byte per 19 cycles.
//  5 nClear low during HI_E -> E=0 and outputs at reset values the same instant.
//    After release, the full init sequence repeats (as in 1).
//  6 Checker: E never rises unless data/RS have been stable for 2 or more cycles.
//    Data/RS never change within 2 cycles after E falls.

Source files
------------

// File: rtl/lcd_nibble_driver_if.sv
// Byte write channel from the MCU into the LCD nibble driver.
// master = MCU side, slave = driver side.
interface lcd_nibble_driver_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;

  modport master (
    output wr_valid,
    output wr_rs,
    output wr_data,
    input  wr_ready,
    input  busy
  );

  modport slave (
    input  wr_valid,
    input  wr_rs,
    input  wr_data,
    output wr_ready,
    output busy
  );
endinterface

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit mode driver: autonomous power-up init, then splits MCU bytes into
// timed high/low nibble strobes followed by a command wait.
module lcd_nibble_driver #(
  parameter int unsigned POWERUP_CYC   = 750000,
  parameter int unsigned INIT_WAIT_CYC = 250000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned E_PULSE_CYC   = 12,
  parameter int unsigned CMD_WAIT_CYC  = 2500,
  parameter int unsigned LONG_WAIT_CYC = 100000
) (
  input  logic                clk_in,
  input  logic                nClear,
  lcd_nibble_driver_if.slave  wr_if,
  output logic [3:0]          lcd_dataout,
  output logic [2:0]          lcd_control
);

  localparam logic [19:0] PowerupLd  = 20'(POWERUP_CYC);
  localparam logic [19:0] InitWaitLd = 20'(INIT_WAIT_CYC);
  localparam logic [19:0] SetupLd    = 20'(SETUP_CYC);
  localparam logic [19:0] EPulseLd   = 20'(E_PULSE_CYC);
  localparam logic [19:0] CmdWaitLd  = 20'(CMD_WAIT_CYC);
  localparam logic [19:0] LongWaitLd = 20'(LONG_WAIT_CYC);

  typedef enum logic [3:0] {
    StPowerup, StInitSu, StInitE, StInitHd, StInitWait, StIdle,
    StHiSu, StHiE, StHiHd, StLoSu, StLoE, StLoHd, StWait
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  nib_q, nib_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        last;
  logic        long_wait;

  always_ff @(posedge clk_in or negedge nClear) begin
    if (!nClear) begin
      state_q <= StPowerup;
      cnt_q   <= PowerupLd;
      idx_q   <= 2'd0;
      nib_q   <= 4'h0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign last      = (cnt_q == 20'd1);
  // Clear display / return home need the long execution time.
  assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nib_d   = nib_q;
    rs_d    = rs_q;
    data_d  = data_q;
    if (state_q != StIdle && !last) begin
      cnt_d = cnt_q - 20'd1;
    end
    unique case (state_q)
      StPowerup: if (last) begin
        state_d = StInitSu;
        cnt_d   = SetupLd;
        idx_d   = 2'd0;
        nib_d   = 4'h3;
        rs_d    = 1'b0;
      end
      StInitSu:  if (last) begin state_d = StInitE;    cnt_d = EPulseLd;   end
      StInitE:   if (last) begin state_d = StInitHd;   cnt_d = SetupLd;    end
      StInitHd:  if (last) begin state_d = StInitWait; cnt_d = InitWaitLd; end
      StInitWait: if (last) begin
        if (idx_q == 2'd3) begin
          state_d = StIdle;
        end else begin
          state_d = StInitSu;
          cnt_d   = SetupLd;
          idx_d   = idx_q + 2'd1;
          nib_d   = (idx_q == 2'd2) ? 4'h2 : 4'h3;
        end
      end
      StIdle: if (wr_if.wr_valid) begin
        state_d = StHiSu;
        cnt_d   = SetupLd;
        data_d  = wr_if.wr_data;
        rs_d    = wr_if.wr_rs;
        nib_d   = wr_if.wr_data[7:4];
      end
      StHiSu: if (last) begin state_d = StHiE;  cnt_d = EPulseLd; end
      StHiE:  if (last) begin state_d = StHiHd; cnt_d = SetupLd;  end
      StHiHd: if (last) begin
        state_d = StLoSu;
        cnt_d   = SetupLd;
        nib_d   = data_q[3:0];
      end
      StLoSu: if (last) begin state_d = StLoE;  cnt_d = EPulseLd; end
      StLoE:  if (last) begin state_d = StLoHd; cnt_d = SetupLd;  end
      StLoHd: if (last) begin
        state_d = StWait;
        cnt_d   = long_wait ? LongWaitLd : CmdWaitLd;
      end
      StWait: if (last) begin state_d = StIdle; end
      default: begin
        state_d = StPowerup;
        cnt_d   = PowerupLd;
      end
    endcase
  end

  // All pins decode directly from flops, so E drops the instant nClear asserts.
  always_comb begin
    wr_if.wr_ready = (state_q == StIdle);
    wr_if.busy     = (state_q != StIdle);
    lcd_dataout    = nib_q;
    lcd_control    = {(state_q == StInitE) || (state_q == StHiE) || (state_q == StLoE),
                      1'b0, rs_q};
  end

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed bench for lcd_nibble_driver: vector table of byte writes plus
// hand-written init, back-to-back, mid-transfer and reset sequences.
module tb_lcd_nibble_driver;

  logic       clk_in = 1'b0;
  logic       nClear = 1'b1;
  logic [3:0] lcd_dataout;
  logic [2:0] lcd_control;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  lcd_nibble_driver_if wr_if ();

  lcd_nibble_driver #(
    .POWERUP_CYC   (10),
    .INIT_WAIT_CYC (8),
    .SETUP_CYC     (2),
    .E_PULSE_CYC   (3),
    .CMD_WAIT_CYC  (5),
    .LONG_WAIT_CYC (20)
  ) dut (
    .clk_in      (clk_in),
    .nClear      (nClear),
    .wr_if       (wr_if.slave),
    .lcd_dataout (lcd_dataout),
    .lcd_control (lcd_control)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         width;
    int         rise;
  } pulse_t;

  pulse_t pq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pin monitor: records E pulses and checks setup/hold of data/RS around E.
  logic   prev_e = 1'b0;
  logic   armed = 1'b0;
  logic [4:0] prev_pins = '0;
  int     stable = 0;
  int     since_fall = 99;
  pulse_t cur_p;

  always @(negedge clk_in) begin
    logic       e;
    logic       changed;
    logic [4:0] pins;
    e    = lcd_control[2];
    pins = {lcd_control[0], lcd_dataout};
    if (!nClear) begin
      prev_e     = 1'b0;
      armed      = 1'b0;
      stable     = 0;
      since_fall = 99;
    end else begin
      if (armed) begin
        changed = (pins != prev_pins);
        stable  = changed ? 0 : stable + 1;
        if (!(!e && prev_e) && since_fall < 99) since_fall++;
        if (changed && since_fall < 2) begin
          n_errors++;
          $display("FAIL hold_after_e: pins changed %0d cycle(s) after E fell", since_fall);
        end
        if (e && !prev_e) begin
          chk("setup_before_e", int'(stable >= 2), 1);
          chk("rw_low", int'(lcd_control[1]), 0);
          cur_p.rs    = lcd_control[0];
          cur_p.nib   = lcd_dataout;
          cur_p.width = 0;
          cur_p.rise  = cyc;
        end
        if (e) cur_p.width++;
        if (!e && prev_e) begin
          since_fall = 0;
          pq.push_back(cur_p);
        end
      end
      armed     = 1'b1;
      prev_e    = e;
      prev_pins = pins;
    end
  end

  task automatic wait_ready(input int from, output int lat);
    int n;
    n = 0;
    while (!wr_if.wr_ready && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    lat = wr_if.wr_ready ? cyc - from : -1;
  endtask

  // Called at a negedge with wr_ready high.
  task automatic do_write(input logic rs, input logic [7:0] d, output int lat);
    int from;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = rs;
    wr_if.wr_data  = d;
    @(posedge clk_in);
    #1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = ~d;
    wr_if.wr_rs    = ~rs;
    @(negedge clk_in);
    from = cyc;
    chk("ready_drop", int'(wr_if.wr_ready), 0);
    wait_ready(from, lat);
  endtask

  // Called while nClear is low; releases reset and checks the whole init sequence.
  task automatic init_seq(input string tag);
    int         rel;
    int         lat;
    logic [3:0] init_nibs [4];
    init_nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
    pq.delete();
    @(negedge clk_in);
    #2 nClear = 1'b1;
    rel = cyc;
    @(negedge clk_in);
    wait_ready(rel, lat);
    chk({tag, "_ready_lat"}, lat, 70);
    chk({tag, "_pulse_count"}, pq.size(), 4);
    for (int i = 0; i < 4 && i < pq.size(); i++) begin
      chk({tag, "_nib"}, int'(pq[i].nib), int'(init_nibs[i]));
      chk({tag, "_rs"}, int'(pq[i].rs), 0);
      chk({tag, "_width"}, pq[i].width, 3);
      chk({tag, "_rise"}, pq[i].rise - rel, 12 + 15 * i);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [3:0] exp_hi;
    logic [3:0] exp_lo;
    int         exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat;
    int busy_run;
    int ready_run;
    int n_acc;
    int n;

    vecs[0] = '{1'b1, 8'h48, 4'h4, 4'h8, 19};
    vecs[1] = '{1'b0, 8'h01, 4'h0, 4'h1, 34};
    vecs[2] = '{1'b1, 8'h01, 4'h0, 4'h1, 19};
    vecs[3] = '{1'b0, 8'h02, 4'h0, 4'h2, 34};
    vecs[4] = '{1'b0, 8'h03, 4'h0, 4'h3, 34};
    vecs[5] = '{1'b0, 8'h04, 4'h0, 4'h4, 19};
    vecs[6] = '{1'b0, 8'h00, 4'h0, 4'h0, 19};
    vecs[7] = '{1'b0, 8'h28, 4'h2, 4'h8, 19};
    vecs[8] = '{1'b1, 8'hC3, 4'hC, 4'h3, 19};

    wr_if.wr_valid = 1'b0;
    wr_if.wr_rs    = 1'b0;
    wr_if.wr_data  = 8'h00;

    // Reset state
    #1 nClear = 1'b0;
    #5;
    chk("rst_ready", int'(wr_if.wr_ready), 0);
    chk("rst_busy", int'(wr_if.busy), 1);
    chk("rst_control", int'(lcd_control), 0);
    chk("rst_data", int'(lcd_dataout), 0);
    @(negedge clk_in);
    init_seq("init");

    // Table-driven byte writes
    for (int i = 0; i < 9; i++) begin
      pq.delete();
      do_write(vecs[i].rs, vecs[i].data, lat);
      chk("vec_lat", lat, vecs[i].exp_lat);
      chk("vec_pulses", pq.size(), 2);
      if (pq.size() == 2) begin
        chk("vec_hi", int'(pq[0].nib), int'(vecs[i].exp_hi));
        chk("vec_lo", int'(pq[1].nib), int'(vecs[i].exp_lo));
        chk("vec_rs_hi", int'(pq[0].rs), int'(vecs[i].rs));
        chk("vec_rs_lo", int'(pq[1].rs), int'(vecs[i].rs));
        chk("vec_width", pq[1].width, 3);
      end
      chk("idle_holds_lo", int'(lcd_dataout), int'(vecs[i].exp_lo));
    end

    // Input changes mid-transfer do not reach the pins; held valid waits for ready
    pq.delete();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h48;
    @(posedge clk_in);
    #1;
    wr_if.wr_rs   = 1'b0;
    wr_if.wr_data = 8'hA5;
    @(negedge clk_in);
    n = cyc;
    chk("mid_ready_drop", int'(wr_if.wr_ready), 0);
    wait_ready(n, lat);
    chk("mid_lat", lat, 19);
    chk("mid_pulses", pq.size(), 2);
    if (pq.size() == 2) begin
      chk("mid_hi", int'(pq[0].nib), 4);
      chk("mid_lo", int'(pq[1].nib), 8);
      chk("mid_rs", int'(pq[1].rs), 1);
    end
    pq.delete();
    @(posedge clk_in);
    #1 wr_if.wr_valid = 1'b0;
    @(negedge clk_in);
    n = cyc;
    wait_ready(n, lat);
    chk("second_lat", lat, 19);
    chk("second_pulses", pq.size(), 2);
    if (pq.size() == 2) begin
      chk("second_hi", int'(pq[0].nib), 4'hA);
      chk("second_lo", int'(pq[1].nib), 4'h5);
      chk("second_rs", int'(pq[0].rs), 0);
    end

    // Back-to-back writes with valid held high
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h5A;
    busy_run  = 0;
    ready_run = 1;
    n_acc     = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_in);
      if (wr_if.wr_ready) begin
        if (busy_run > 0) begin
          chk("b2b_busy_run", busy_run, 19);
          n_acc++;
        end
        busy_run = 0;
        ready_run++;
      end else begin
        if (ready_run > 0) chk("b2b_ready_run", ready_run, 1);
        ready_run = 0;
        busy_run++;
      end
    end
    chk("b2b_accepts", int'(n_acc >= 2), 1);
    wr_if.wr_valid = 1'b0;
    @(negedge clk_in);
    n = cyc;
    wait_ready(n, lat);
    chk("b2b_drain", int'(lat >= 0), 1);

    // Reset asserted while E is high
    pq.delete();
    @(negedge clk_in);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_rs    = 1'b1;
    wr_if.wr_data  = 8'h48;
    @(posedge clk_in);
    #1 wr_if.wr_valid = 1'b0;
    n = 0;
    while (!lcd_control[2] && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    chk("e_high_before_reset", int'(lcd_control[2]), 1);
    #2 nClear = 1'b0;
    #1;
    chk("midrst_control", int'(lcd_control), 0);
    chk("midrst_data", int'(lcd_dataout), 0);
    chk("midrst_ready", int'(wr_if.wr_ready), 0);
    chk("midrst_busy", int'(wr_if.busy), 1);
    @(negedge clk_in);
    init_seq("reinit");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
